// File: rtl/cordic_arbiter.sv
// Round-robin front end for one shared iterative CORDIC sin/cos engine.
// Holds the engine request for a whole job, then forces a two-cycle idle gap.
module cordic_arbiter #(
  parameter int N       = 4,
  parameter int LAT_MIN = 16,
  parameter int TIMEOUT = 64
) (
  input  logic            i_clk,
  input  logic            i_nrst,
  input  logic [N-1:0]    i_req,
  input  logic [16*N-1:0] i_theta,
  output logic [N-1:0]    o_ack,
  output logic            o_err,
  output logic [15:0]     o_sin,
  output logic [15:0]     o_cos,
  output logic            o_busy,
  output logic            o_cordic_req,
  output logic [15:0]     o_cordic_theta,
  input  logic [15:0]     i_cordic_sin,
  input  logic [15:0]     i_cordic_cos,
  input  logic            i_cordic_ack
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] LAT_C = 8'(LAT_MIN);
  localparam logic [7:0] TMO_C = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state, state_d;
  logic [IW-1:0] ptr, ptr_d;
  logic [IW-1:0] owner, owner_d;
  logic [IW-1:0] pick, idx;
  logic [IW:0]   sum;
  logic          found;
  logic [7:0]    cnt, cnt_d;
  logic [N-1:0]  ack_d;
  logic          err_d, req_d, busy_d;
  logic [15:0]   sin_d, cos_d, theta_d;

  // first set request at or after ptr, wrapping at N-1
  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!found && i_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    owner_d = owner;
    cnt_d   = cnt;
    ack_d   = '0;
    err_d   = 1'b0;
    sin_d   = o_sin;
    cos_d   = o_cos;
    theta_d = o_cordic_theta;
    req_d   = o_cordic_req;
    busy_d  = o_busy;
    unique case (state)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          theta_d = i_theta[{pick, 4'b0000} +: 16];
          req_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt != 8'hFF) cnt_d = cnt + 8'd1;
        if (i_cordic_ack && cnt >= LAT_C) begin
          sin_d        = i_cordic_sin;
          cos_d        = i_cordic_cos;
          ack_d[owner] = 1'b1;
          req_d        = 1'b0;
          state_d      = DONE;
        end else if (cnt == TMO_C) begin
          sin_d        = '0;
          cos_d        = '0;
          ack_d[owner] = 1'b1;
          err_d        = 1'b1;
          req_d        = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: begin
        ptr_d   = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state          <= IDLE;
      ptr            <= '0;
      owner          <= '0;
      cnt            <= '0;
      o_ack          <= '0;
      o_err          <= 1'b0;
      o_sin          <= '0;
      o_cos          <= '0;
      o_busy         <= 1'b0;
      o_cordic_req   <= 1'b0;
      o_cordic_theta <= '0;
    end else begin
      state          <= state_d;
      ptr            <= ptr_d;
      owner          <= owner_d;
      cnt            <= cnt_d;
      o_ack          <= ack_d;
      o_err          <= err_d;
      o_sin          <= sin_d;
      o_cos          <= cos_d;
      o_busy         <= busy_d;
      o_cordic_req   <= req_d;
      o_cordic_theta <= theta_d;
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: engine model plus a scoreboard of
// expected acks, with one task per scenario.
module tb_cordic_arbiter;

  localparam int N = 4;
  localparam logic [15:0] SK = 16'h5234;
  localparam logic [15:0] CK = 16'h1678;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [16*N-1:0] theta;
  logic [N-1:0]    o_ack;
  logic            o_err;
  logic [15:0]     o_sin, o_cos;
  logic            o_busy, o_cordic_req;
  logic [15:0]     o_cordic_theta;
  logic [15:0]     eng_sin, eng_cos;
  logic            eng_ack;

  logic [15:0] th [N] = '{16'h4000, 16'h1111, 16'h2222, 16'h3333};

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int eng_mode = 0;
  logic [7:0] ec = '0;

  typedef struct {
    logic [N-1:0] ack;
    logic         err;
    logic [15:0]  sin;
    logic [15:0]  cos;
    int           at;
  } exp_t;

  exp_t sb[$];

  assign theta = {th[3], th[2], th[1], th[0]};

  cordic_arbiter #(.N(N), .LAT_MIN(16), .TIMEOUT(64)) dut (
    .i_clk          (clk),
    .i_nrst         (nrst),
    .i_req          (req),
    .i_theta        (theta),
    .o_ack          (o_ack),
    .o_err          (o_err),
    .o_sin          (o_sin),
    .o_cos          (o_cos),
    .o_busy         (o_busy),
    .o_cordic_req   (o_cordic_req),
    .o_cordic_theta (o_cordic_theta),
    .i_cordic_sin   (eng_sin),
    .i_cordic_cos   (eng_cos),
    .i_cordic_ack   (eng_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // engine model: mode 0 acks at 17 req-high cycles, 1 never, 2 always
  always @(posedge clk) ec <= o_cordic_req ? ec + 8'd1 : 8'd0;
  assign eng_ack = o_cordic_req &&
                   (eng_mode == 2 || (eng_mode == 0 && ec == 8'd17));
  assign eng_sin = o_cordic_theta ^ SK;
  assign eng_cos = o_cordic_theta ^ CK;

  function automatic exp_t job(int k, int at, bit err);
    exp_t x;
    x.ack = 4'b0001 << k;
    x.err = err;
    x.sin = err ? 16'h0000 : th[k] ^ SK;
    x.cos = err ? 16'h0000 : th[k] ^ CK;
    x.at  = at;
    return x;
  endfunction

  task automatic test_reset();
    nrst = 1'b0;
    req  = '1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({o_ack, o_err, o_sin, o_cos, o_busy, o_cordic_req, o_cordic_theta} !== '0)
      $display("FAIL reset_state: ack=%b err=%b sin=%h cos=%h busy=%b req=%b th=%h, want all 0",
               o_ack, o_err, o_sin, o_cos, o_busy, o_cordic_req, o_cordic_theta);
    else passed++;
    req  = '0;
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (o_busy !== 1'b0 || o_cordic_req !== 1'b0 || o_ack !== '0)
      $display("FAIL idle_no_req: busy=%b req=%b ack=%b, want 0 0 0",
               o_busy, o_cordic_req, o_ack);
    else passed++;
  endtask

  task automatic test_single();
    exp_t e;
    bit bad = 0;
    eng_mode = 0;
    @(posedge clk);
    #1;
    req = 4'b0001;
    sb.push_back(job(0, cyc + 19, 0));
    for (int t = 0; t < 100 && sb.size() > 0; t++) begin
      @(negedge clk);
      if (o_cordic_req && (o_cordic_theta !== 16'h4000 || o_busy !== 1'b1)) bad = 1;
      if (o_ack != '0) begin
        total++;
        e = sb.pop_front();
        if (o_ack !== e.ack || o_err !== e.err || o_sin !== e.sin ||
            o_cos !== e.cos || o_busy !== 1'b1 || cyc != e.at)
          $display("FAIL single_ack: ack=%b err=%b sin=%h cos=%h cyc=%0d, want %b %b %h %h %0d",
                   o_ack, o_err, o_sin, o_cos, cyc, e.ack, e.err, e.sin, e.cos, e.at);
        else passed++;
        req = req & ~o_ack;
      end
    end
    total++;
    if (sb.size() != 0 || bad)
      $display("FAIL single_run: pending=%0d theta_bad=%0d, want 0 0", sb.size(), bad);
    else passed++;
  endtask

  task automatic test_pair();
    exp_t e;
    bit seen = 0, rose = 0;
    int gap = 0;
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    req  = 4'b1010;
    sb.push_back(job(1, cyc + 19, 0));
    sb.push_back(job(3, cyc + 39, 0));
    for (int t = 0; t < 200 && sb.size() > 0; t++) begin
      @(negedge clk);
      if (o_ack != '0) begin
        total++;
        e = sb.pop_front();
        if (o_ack !== e.ack || o_err !== e.err || o_sin !== e.sin ||
            o_cos !== e.cos || cyc != e.at)
          $display("FAIL pair_ack: ack=%b err=%b sin=%h cos=%h cyc=%0d, want %b %b %h %h %0d",
                   o_ack, o_err, o_sin, o_cos, cyc, e.ack, e.err, e.sin, e.cos, e.at);
        else passed++;
        req  = req & ~o_ack;
        seen = 1;
      end
      if (seen && !rose) begin
        if (o_cordic_req) rose = 1;
        else gap++;
      end
    end
    total++;
    if (sb.size() != 0 || gap != 2)
      $display("FAIL pair_gap: pending=%0d gap=%0d, want 0 2", sb.size(), gap);
    else passed++;
  endtask

  task automatic test_round_robin();
    exp_t e;
    @(posedge clk);
    #1;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) sb.push_back(job(i % 4, cyc + 19 + 20 * i, 0));
    for (int t = 0; t < 400 && sb.size() > 0; t++) begin
      @(negedge clk);
      if (o_ack != '0) begin
        total++;
        e = sb.pop_front();
        if (o_ack !== e.ack || o_err !== e.err || o_sin !== e.sin ||
            o_cos !== e.cos || cyc != e.at)
          $display("FAIL rr_ack: ack=%b err=%b sin=%h cos=%h cyc=%0d, want %b %b %h %h %0d",
                   o_ack, o_err, o_sin, o_cos, cyc, e.ack, e.err, e.sin, e.cos, e.at);
        else passed++;
        if (sb.size() == 0) req = '0;
      end
    end
    total++;
    if (sb.size() != 0)
      $display("FAIL rr_done: pending=%0d, want 0", sb.size());
    else passed++;
  endtask

  task automatic test_timeout();
    exp_t e;
    eng_mode = 1;
    @(posedge clk);
    #1;
    req = 4'b0110;
    sb.push_back(job(1, cyc + 65, 1));
    sb.push_back(job(2, cyc + 85, 0));
    for (int t = 0; t < 200 && sb.size() > 0; t++) begin
      @(negedge clk);
      if (o_ack != '0) begin
        total++;
        e = sb.pop_front();
        if (o_ack !== e.ack || o_err !== e.err || o_sin !== e.sin ||
            o_cos !== e.cos || cyc != e.at)
          $display("FAIL timeout_ack: ack=%b err=%b sin=%h cos=%h cyc=%0d, want %b %b %h %h %0d",
                   o_ack, o_err, o_sin, o_cos, cyc, e.ack, e.err, e.sin, e.cos, e.at);
        else passed++;
        req      = req & ~o_ack;
        eng_mode = 0;
      end
    end
    total++;
    if (sb.size() != 0)
      $display("FAIL timeout_done: pending=%0d, want 0", sb.size());
    else passed++;
  endtask

  task automatic test_stale();
    exp_t e;
    eng_mode = 2;
    @(posedge clk);
    #1;
    req = 4'b0100;
    sb.push_back(job(2, cyc + 18, 0));
    for (int t = 0; t < 100 && sb.size() > 0; t++) begin
      @(negedge clk);
      if (o_ack != '0) begin
        total++;
        e = sb.pop_front();
        if (o_ack !== e.ack || o_err !== e.err || o_sin !== e.sin ||
            o_cos !== e.cos || cyc != e.at)
          $display("FAIL stale_ack: ack=%b err=%b sin=%h cos=%h cyc=%0d, want %b %b %h %h %0d",
                   o_ack, o_err, o_sin, o_cos, cyc, e.ack, e.err, e.sin, e.cos, e.at);
        else passed++;
        req = req & ~o_ack;
      end
    end
    eng_mode = 0;
    total++;
    if (sb.size() != 0)
      $display("FAIL stale_done: pending=%0d, want 0", sb.size());
    else passed++;
  endtask

  task automatic test_reset_midjob();
    exp_t e;
    eng_mode = 0;
    @(posedge clk);
    #1;
    req = 4'b1001;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (o_cordic_req !== 1'b1 || o_busy !== 1'b1 || o_cordic_theta !== th[3])
      $display("FAIL midjob_run: req=%b busy=%b th=%h, want 1 1 %h",
               o_cordic_req, o_busy, o_cordic_theta, th[3]);
    else passed++;
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    total++;
    if ({o_ack, o_err, o_sin, o_cos, o_busy, o_cordic_req, o_cordic_theta} !== '0)
      $display("FAIL midjob_reset: ack=%b err=%b sin=%h cos=%h busy=%b req=%b th=%h, want all 0",
               o_ack, o_err, o_sin, o_cos, o_busy, o_cordic_req, o_cordic_theta);
    else passed++;
    sb.push_back(job(0, cyc + 19, 0));
    sb.push_back(job(3, cyc + 39, 0));
    for (int t = 0; t < 200 && sb.size() > 0; t++) begin
      @(negedge clk);
      if (o_ack != '0) begin
        total++;
        e = sb.pop_front();
        if (o_ack !== e.ack || o_err !== e.err || o_sin !== e.sin ||
            o_cos !== e.cos || cyc != e.at)
          $display("FAIL midjob_ack: ack=%b err=%b sin=%h cos=%h cyc=%0d, want %b %b %h %h %0d",
                   o_ack, o_err, o_sin, o_cos, cyc, e.ack, e.err, e.sin, e.cos, e.at);
        else passed++;
        req = req & ~o_ack;
      end
    end
    total++;
    if (sb.size() != 0)
      $display("FAIL midjob_done: pending=%0d, want 0", sb.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_round_robin();
    test_timeout();
    test_stale();
    test_reset_midjob();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
